// File: rtl/direction_queue.sv
// direction_queue: conditions the four direction push-buttons and buffers turns
// for the snake engine.
// Chain: two-flop synchroniser -> per-key debounce -> press-edge detect ->
// lowest-index arbitration -> duplicate/reversal filter -> small turn FIFO.
// One buffered turn is released per move_tick.
// Optional build macro DIRQ_GAMEOVER_FREEZE_EN: while game_over is high the FIFO
// is flushed every cycle and press events are discarded (cur_dir holds).
// Direction encoding: 00 up, 01 right, 10 down, 11 left.
module direction_queue #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter logic [1:0]  INIT_DIR        = 2'b01
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [3:0]                   keys_in,
  input  logic                         move_tick,
  input  logic                         game_over,
  output logic [1:0]                   direction,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic                         overflow
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(QUEUE_DEPTH);
  localparam logic [3:0]       KEY_IDLE = KEY_ACTIVE_LOW ? 4'hF : 4'h0;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] key_pressed;

  // Two flops per key; reset to the released level so no phantom press appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= KEY_IDLE;
      sync2_q <= KEY_IDLE;
    end else begin
      sync1_q <= keys_in;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity: 1 means pressed from here on.
  assign key_pressed = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  // ---------------------------------------------------------------------------
  // Debounce and press-edge detect
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       deb_q, deb_d;
  logic [3:0]       deb_prev_q;
  logic [3:0]       press_evt;

  // A state change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      deb_d[i] = deb_q[i];
      if (key_pressed[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce state, counters and the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      deb_q      <= '0;
      deb_prev_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  // Releases produce nothing; only 0->1 of the debounced state is an event.
  assign press_evt = deb_q & ~deb_prev_q;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic       cand_valid;
  logic [1:0] cand_dir;

  // Lowest key index wins; simultaneous higher-index presses are discarded.
  always_comb begin
    cand_valid = 1'b1;
    cand_dir   = 2'b00;
    if (press_evt[0]) begin
      cand_dir = 2'b00;
    end else if (press_evt[1]) begin
      cand_dir = 2'b01;
    end else if (press_evt[2]) begin
      cand_dir = 2'b10;
    end else if (press_evt[3]) begin
      cand_dir = 2'b11;
    end else begin
      cand_valid = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Game-over freeze (optional)
  // ---------------------------------------------------------------------------
  logic freeze;
`ifdef DIRQ_GAMEOVER_FREEZE_EN
  assign freeze = game_over;
`else
  logic unused_game_over;
  assign unused_game_over = game_over;
  assign freeze           = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Filter and turn FIFO
  // ---------------------------------------------------------------------------
  logic [1:0]     fifo_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic             overflow_q, overflow_d;
  logic [1:0]       tail;
  logic             accept, push, pop;

  // Newest buffered turn, or the live direction when nothing is queued.
  assign tail = (count_q != '0) ? fifo_q[wr_ptr_q - PTR_W'(1)] : cur_dir_q;

  // Duplicates and 180-degree reversals of the tail are silently rejected.
  assign accept = cand_valid && !freeze &&
                  (cand_dir != tail) && (cand_dir != (tail ^ 2'b10));
  assign pop    = move_tick && (count_q != '0) && !freeze;
  // A full queue still takes a turn when a pop frees a slot in the same cycle.
  assign push   = accept && ((count_q < DEPTH) || pop);

  // Next-state for pointers, occupancy, live direction and overflow pulse.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    cur_dir_d  = cur_dir_q;
    overflow_d = accept && !push;
    if (freeze) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        cur_dir_d = fifo_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cur_dir_q  <= INIT_DIR;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= cand_dir;
      end
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cur_dir_q  <= cur_dir_d;
      overflow_q <= overflow_d;
    end
  end

  // Zero-latency view: the engine sees the head turn in the very tick it is popped.
  assign direction   = (count_q != '0) ? fifo_q[rd_ptr_q] : cur_dir_q;
  assign queue_count = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_direction_queue.sv
// tb_direction_queue: scoreboard bench for direction_queue.
// Accepted turns are pushed into a model queue when a press is driven and
// popped/compared against the DUT direction on each move_tick.
module tb_direction_queue;

  localparam int unsigned DEB = 4;
  localparam int unsigned QD  = 4;
`ifdef DIRQ_GAMEOVER_FREEZE_EN
  localparam bit FREEZE = 1'b1;
`else
  localparam bit FREEZE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] keys_in = 4'hF;
  logic       move_tick = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] direction;
  logic [2:0] queue_count;
  logic       overflow;

  direction_queue #(
    .DEBOUNCE_CYCLES(DEB),
    .QUEUE_DEPTH(QD),
    .KEY_ACTIVE_LOW(1'b1),
    .INIT_DIR(2'b01)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .keys_in(keys_in),
    .move_tick(move_tick),
    .game_over(game_over),
    .direction(direction),
    .queue_count(queue_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model: queued turns and the engine's live direction.
  logic [1:0] mq[$];
  logic [1:0] mcur = 2'b01;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_head();
    return (mq.size() > 0) ? mq[0] : mcur;
  endfunction

  // Applies one press (lowest set bit of mask) to the model; optional same-cycle tick.
  task automatic model_press(input logic [3:0] mask, input bit tk, output bit ovf);
    logic [1:0] d, tl;
    bit         full, popped;
    ovf = 1'b0;
    if (FREEZE && game_over) return;
    d      = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
    tl     = (mq.size() > 0) ? mq[$] : mcur;
    full   = (mq.size() >= QD);
    popped = 1'b0;
    if (tk && mq.size() > 0) begin
      mcur   = mq.pop_front();
      popped = 1'b1;
    end
    if (d == tl || d == (tl ^ 2'b10)) return;
    if (full && !popped) ovf = 1'b1;
    else mq.push_back(d);
  endtask

  // Standard press: keys held 4 cycles; the push lands on the 7th edge.
  task automatic press(input string tag, input logic [3:0] mask, input bit tk);
    bit exp_ovf;
    @(posedge clk); #1 keys_in = ~mask;
    repeat (4) @(posedge clk);
    #1 keys_in = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    if (tk) move_tick = 1'b1;
    @(negedge clk);
    if (tk) check({tag, "_tickdir"}, 32'(direction), 32'(model_head()));
    @(posedge clk); #1 move_tick = 1'b0;
    model_press(mask, tk, exp_ovf);
    @(negedge clk);
    check({tag, "_cnt"}, 32'(queue_count), 32'(mq.size()));
    check({tag, "_dir"}, 32'(direction), 32'(model_head()));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    @(negedge clk);
    check({tag, "_ovf_end"}, 32'(overflow), 32'd0);
    repeat (12) @(posedge clk);
  endtask

  task automatic tick(input string tag);
    @(posedge clk); #1 move_tick = 1'b1;
    @(negedge clk);
    check({tag, "_dir"}, 32'(direction), 32'(model_head()));
    @(posedge clk); #1 move_tick = 1'b0;
    if (mq.size() > 0) mcur = mq.pop_front();
    @(negedge clk);
    check({tag, "_cnt"}, 32'(queue_count), 32'(mq.size()));
    check({tag, "_after"}, 32'(direction), 32'(model_head()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_dir", 32'(direction), 32'd1);
    check("rst_cnt", 32'(queue_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Idle keys produce nothing.
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_cnt", 32'(queue_count), 32'd0);

    // Too-short press is filtered out.
    @(posedge clk); #1 keys_in = 4'b1110;
    repeat (3) @(posedge clk);
    #1 keys_in = 4'hF;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("short_cnt", 32'(queue_count), 32'd0);

    // Long press yields exactly one turn.
    @(posedge clk); #1 keys_in = 4'b1110;
    repeat (10) @(posedge clk);
    #1 keys_in = 4'hF;
    mq.push_back(2'd0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("long_cnt", 32'(queue_count), 32'd1);
    check("long_dir", 32'(direction), 32'd0);
    tick("long_tick");

    // Back to right, then reversal / duplicate / valid turn.
    press("to_right", 4'b0010, 1'b0);
    tick("t_right");
    press("rev_left", 4'b1000, 1'b0);
    press("dup_right", 4'b0010, 1'b0);
    press("down", 4'b0100, 1'b0);
    tick("t_down");
    press("right2", 4'b0010, 1'b0);
    tick("t_right2");

    // Double tap inside one move period.
    press("dt_up", 4'b0001, 1'b0);
    press("dt_left", 4'b1000, 1'b0);
    tick("dt_t1");
    tick("dt_t2");

    // Return to right and fill the queue.
    press("r_up", 4'b0001, 1'b0);
    tick("r_t1");
    press("r_right", 4'b0010, 1'b0);
    tick("r_t2");
    press("f_up", 4'b0001, 1'b0);
    press("f_left", 4'b1000, 1'b0);
    press("f_down", 4'b0100, 1'b0);
    press("f_right", 4'b0010, 1'b0);
    press("ovf_up", 4'b0001, 1'b0);
    press("full_tick_up", 4'b0001, 1'b1);
    for (int i = 0; i < 4; i++) tick("drain");
    tick("empty_tick");

    // Simultaneous presses: lowest index (down) is a reversal, left is discarded.
    press("arb_dl", 4'b1100, 1'b0);
    press("arb_rl", 4'b1010, 1'b0);
    tick("arb_tick");

    // Game-over behaviour.
    press("go_up", 4'b0001, 1'b0);
    press("go_left", 4'b1000, 1'b0);
    @(posedge clk); #1 game_over = 1'b1;
    @(posedge clk);
    if (FREEZE) mq.delete();
    @(negedge clk);
    check("go_cnt", 32'(queue_count), 32'(mq.size()));
    press("go_down", 4'b0100, 1'b0);
    @(posedge clk); #1 game_over = 1'b0;
    for (int i = 0; i < 4 && mq.size() > 0; i++) tick("go_drain");
    tick("go_empty");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
